// File: rtl/sync_ram_pkg.sv
// rtl/sync_ram_pkg.sv - shared constants, FSM encoding and byte-merge helper for sync_ram
package sync_ram_pkg;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

    // Widest word the merge helper handles; callers cast in and out of this width.
    localparam int MERGE_MAX_W = 256;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    function automatic logic [MERGE_MAX_W-1:0] byte_merge(
        input logic [MERGE_MAX_W-1:0]   old_word,
        input logic [MERGE_MAX_W-1:0]   new_word,
        input logic [MERGE_MAX_W/8-1:0] be
    );
        logic [MERGE_MAX_W-1:0] res;
        res = old_word;
        for (int i = 0; i < MERGE_MAX_W/8; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sync_ram_rd_pipe.sv
// rtl/sync_ram_rd_pipe.sv - read valid/data pipeline for one or two cycles of latency, with flush
module sync_ram_rd_pipe #(
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    logic              v1;
    logic [DATA_W-1:0] d1;

    // Data registers only load on a valid beat so the output holds between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            d1 <= '0;
        end else if (flush) begin
            v1 <= 1'b0;
        end else begin
            v1 <= in_valid;
            if (in_valid) begin
                d1 <= in_data;
            end
        end
    end

    if (RD_LAT == 1) begin : g_lat1
        assign out_valid = v1;
        assign out_data  = d1;
    end else begin : g_lat2
        logic              v2;
        logic [DATA_W-1:0] d2;

        always_ff @(posedge clk) begin
            if (rst) begin
                v2 <= 1'b0;
                d2 <= '0;
            end else if (flush) begin
                v2 <= 1'b0;
            end else begin
                v2 <= v1;
                if (v1) begin
                    d2 <= d1;
                end
            end
        end

        assign out_valid = v2;
        assign out_data  = d2;
    end

endmodule

// File: rtl/sync_ram.sv
// rtl/sync_ram.sv - simple-dual-port synchronous RAM with byte enables, read latency 1/2 and clear engine
module sync_ram
    import sync_ram_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 5,
    parameter int DEPTH    = 2**ADDR_W,
    parameter int RD_LAT   = 1,
    parameter int RDW_MODE = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    output logic                busy,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_be,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic                rd_valid,
    output logic [DATA_W-1:0]   rd_data
);

    localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    state_t            state, state_next;
    logic [ADDR_W-1:0] cnt, cnt_next;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              ports_open;
    logic              wr_in_range, rd_in_range;
    logic              wr_fire, rd_fire, collide;
    logic [IDX_W-1:0]  wr_idx, rd_idx, cnt_idx;
    logic [DATA_W-1:0] wr_merged, clr_word, rd_result;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // A clr pulse restarts the sweep from word 0 regardless of the current state.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (clr) begin
            state_next = ST_CLEAR;
            cnt_next   = '0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    if (cnt == LAST) begin
                        state_next = ST_IDLE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
                ST_IDLE: begin
                    state_next = ST_IDLE;
                end
                default: begin
                    state_next = ST_CLEAR;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    assign busy       = (state == ST_CLEAR);
    assign ports_open = (state == ST_IDLE) && !rst && !clr;

    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_L);
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_L);
    assign wr_fire     = ports_open && wr_en && wr_in_range;
    assign rd_fire     = ports_open && rd_en;
    assign collide     = wr_fire && (wr_addr == rd_addr);

    assign wr_idx  = wr_addr[IDX_W-1:0];
    assign rd_idx  = rd_addr[IDX_W-1:0];
    assign cnt_idx = cnt[IDX_W-1:0];

    assign wr_merged = DATA_W'(byte_merge(MERGE_MAX_W'(mem[wr_idx]),
                                          MERGE_MAX_W'(wr_data),
                                          (MERGE_MAX_W/8)'(wr_be)));
    assign clr_word  = DATA_W'(byte_merge(MERGE_MAX_W'(mem[cnt_idx]), '0, '1));

    always_ff @(posedge clk) begin
        if (state == ST_CLEAR && !rst && !clr) begin
            mem[cnt_idx] <= clr_word;
        end else if (wr_fire) begin
            mem[wr_idx] <= wr_merged;
        end
    end

    // Out-of-range reads still complete, returning zero.
    always_comb begin
        rd_result = '0;
        if (rd_in_range) begin
            if (RDW_MODE == RDW_WRITE_FIRST && collide) begin
                rd_result = wr_merged;
            end else begin
                rd_result = mem[rd_idx];
            end
        end
    end

    sync_ram_rd_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk       (clk),
        .rst       (rst),
        .flush     (clr),
        .in_valid  (rd_fire),
        .in_data   (rd_result),
        .out_valid (rd_valid),
        .out_data  (rd_data)
    );

endmodule

// File: tb/tb_sync_ram.sv
// tb/tb_sync_ram.sv - scoreboard bench for sync_ram: read-first/latency-1/depth-20 and write-first/latency-2/depth-32
module tb_sync_ram;

    logic        clk = 1'b0;
    logic        rst, clr, wr_en, rd_en;
    logic [4:0]  wr_addr, rd_addr;
    logic [15:0] wr_data;
    logic [1:0]  wr_be;
    logic        busy0, busy1, v0, v1;
    logic [15:0] d0, d1;

    always #5 clk = ~clk;

    sync_ram #(.DATA_W(16), .ADDR_W(5), .DEPTH(20), .RD_LAT(1), .RDW_MODE(0)) u0 (
        .clk(clk), .rst(rst), .clr(clr), .busy(busy0),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(v0), .rd_data(d0));

    sync_ram #(.DATA_W(16), .ADDR_W(5), .DEPTH(32), .RD_LAT(2), .RDW_MODE(1)) u1 (
        .clk(clk), .rst(rst), .clr(clr), .busy(busy1),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(v1), .rd_data(d1));

    typedef struct {
        logic [15:0] data;
        int          at;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   bc0 = 0;
    int   bc1 = 0;
    bit   mon_on = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (busy0) bc0++;
        if (busy1) bc1++;
    end

    always @(negedge clk) begin
        if (mon_on && v0) begin
            if (q0.size() == 0) begin
                check("u0_spurious_valid", 32'd1, 32'd0);
            end else begin
                e0 = q0.pop_front();
                check("u0_rd_data", 32'(d0), 32'(e0.data));
                check("u0_rd_cycle", 32'(cyc), 32'(e0.at));
            end
        end
        if (mon_on && v1) begin
            if (q1.size() == 0) begin
                check("u1_spurious_valid", 32'd1, 32'd0);
            end else begin
                e1 = q1.pop_front();
                check("u1_rd_data", 32'(d1), 32'(e1.data));
                check("u1_rd_cycle", 32'(cyc), 32'(e1.at));
            end
        end
    end

    task automatic op(input logic we, input logic [4:0] wa, input logic [15:0] wd, input logic [1:0] be,
                      input logic re, input logic [4:0] ra,
                      input logic p0, input logic [15:0] x0, input logic p1, input logic [15:0] x1);
        exp_t t;
        wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
        rd_en = re; rd_addr = ra;
        if (re && p0) begin
            t.data = x0; t.at = cyc + 1;
            q0.push_back(t);
        end
        if (re && p1) begin
            t.data = x1; t.at = cyc + 2;
            q1.push_back(t);
        end
        @(posedge clk); #2;
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [15:0] d, input logic [1:0] be);
        op(1'b1, a, d, be, 1'b0, 5'd0, 1'b0, 16'h0, 1'b0, 16'h0);
    endtask

    task automatic rd(input logic [4:0] a, input logic [15:0] x0, input logic [15:0] x1);
        op(1'b0, 5'd0, 16'h0, 2'b00, 1'b1, a, 1'b1, x0, 1'b1, x1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            if (!busy0 && !busy1) break;
            @(posedge clk); #2;
        end
        check("idle_timeout", 32'(busy0 | busy1), 32'd0);
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        wr_addr = '0; rd_addr = '0; wr_data = '0; wr_be = '0;
        @(posedge clk); #2;
        rst = 1'b0; bc0 = 0; bc1 = 0; mon_on = 1'b1;

        check("rst_busy0", 32'(busy0), 32'd1);
        check("rst_busy1", 32'(busy1), 32'd1);
        check("rst_valid0", 32'(v0), 32'd0);
        check("rst_valid1", 32'(v1), 32'd0);
        check("rst_data0", 32'(d0), 32'd0);
        check("rst_data1", 32'(d1), 32'd0);
        wait_idle();
        check("rst_busy_len0", 32'(bc0), 32'd20);
        check("rst_busy_len1", 32'(bc1), 32'd32);

        for (int a = 0; a < 32; a++) rd(5'(a), 16'h0000, 16'h0000);

        wr(5'd3, 16'hABCD, 2'b11);
        wr(5'd3, 16'h0012, 2'b01);
        rd(5'd3, 16'hAB12, 16'hAB12);

        wr(5'd7, 16'h1111, 2'b11);
        op(1'b1, 5'd7, 16'h2222, 2'b11, 1'b1, 5'd7, 1'b1, 16'h1111, 1'b1, 16'h2222);
        rd(5'd7, 16'h2222, 16'h2222);
        op(1'b1, 5'd7, 16'h3344, 2'b01, 1'b1, 5'd7, 1'b1, 16'h2222, 1'b1, 16'h2244);
        rd(5'd7, 16'h2244, 16'h2244);

        wr(5'd0, 16'h1000, 2'b11);
        wr(5'd1, 16'h1001, 2'b11);
        wr(5'd2, 16'h1002, 2'b11);
        rd(5'd0, 16'h1000, 16'h1000);
        rd(5'd1, 16'h1001, 16'h1001);
        rd(5'd2, 16'h1002, 16'h1002);

        wr(5'd25, 16'h5555, 2'b11);
        rd(5'd25, 16'h0000, 16'h5555);
        wr(5'd3, 16'hFFFF, 2'b00);
        rd(5'd3, 16'hAB12, 16'hAB12);

        op(1'b1, 5'd4, 16'h4444, 2'b11, 1'b1, 5'd3, 1'b1, 16'hAB12, 1'b1, 16'hAB12);
        rd(5'd4, 16'h4444, 16'h4444);

        op(1'b0, 5'd0, 16'h0, 2'b00, 1'b1, 5'd3, 1'b1, 16'hAB12, 1'b0, 16'h0);
        clr = 1'b1;
        @(posedge clk); #2;
        clr = 1'b0; bc0 = 0; bc1 = 0;
        check("clr_valid0", 32'(v0), 32'd0);
        check("clr_valid1", 32'(v1), 32'd0);
        check("clr_hold0", 32'(d0), 32'hAB12);
        check("clr_hold1", 32'(d1), 32'h4444);
        check("clr_busy0", 32'(busy0), 32'd1);
        check("clr_busy1", 32'(busy1), 32'd1);
        repeat (3) begin
            @(posedge clk); #2;
        end
        wr(5'd5, 16'h7777, 2'b11);
        op(1'b0, 5'd0, 16'h0, 2'b00, 1'b1, 5'd5, 1'b0, 16'h0, 1'b0, 16'h0);
        wait_idle();
        check("clr_busy_len0", 32'(bc0), 32'd20);
        check("clr_busy_len1", 32'(bc1), 32'd32);
        rd(5'd5, 16'h0000, 16'h0000);
        rd(5'd3, 16'h0000, 16'h0000);
        rd(5'd25, 16'h0000, 16'h0000);

        repeat (5) begin
            @(posedge clk); #2;
        end
        check("q0_drained", 32'(q0.size()), 32'd0);
        check("q1_drained", 32'(q1.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sync_ram.md
# sync_ram

Parametrised simple-dual-port synchronous RAM: one write port with byte enables and one read port with configurable read latency and defined read-during-write behaviour. After reset, or on request, a built-in clear engine zeroes every word. It is the general storage primitive for register files, scratchpads and FIFO backing stores, replacing the asynchronous 32x16 memory.

## Interface
- DATA_W, 16: word width in bits; must be a multiple of 8.
- ADDR_W, 5: address width.
- DEPTH, 2**ADDR_W: number of words; must satisfy 1 <= DEPTH <= 2**ADDR_W.
- RD_LAT, 1: read latency in cycles; legal values are 1 and 2.
- RDW_MODE, 0: same-address collision policy; 0 = read-first (old data), 1 = write-first (new data).

Ports:
- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- clr  in  1  single-cycle pulse that starts a full clear.
- busy  out  1  clear engine active; both ports ignored.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_be  in  DATA_W/8  byte enables; bit i covers bits [8i+7:8i].
- rd_en  in  1  read strobe.
- rd_addr  in  ADDR_W  read address.
- rd_valid  out  1  rd_data holds the result of an accepted read.
- rd_data  out  DATA_W  read result.

## Operation
- FSM has two states, CLEAR and IDLE. rst or clr forces CLEAR with the clear counter at 0. In CLEAR, word[cnt] is written with 0 each cycle and cnt increments. CLEAR moves to IDLE after word DEPTH-1 is written. Reset-to-IDLE takes exactly DEPTH cycles.
- clr asserted while already in CLEAR restarts the counter at 0.
- busy=1 exactly while in CLEAR. In CLEAR, wr_en and rd_en are dropped, not queued.
- In IDLE, a write on cycle k updates only the bytes selected by wr_be. If wr_be is 0, the write is a no-op.
- In IDLE, a read on cycle k is accepted.
- Collision (wr_en, rd_en, and wr_addr==rd_addr in the same cycle):
  - RDW_MODE=0 returns the pre-write word.
  - RDW_MODE=1 returns the merged word: new bytes where wr_be=1, old bytes elsewhere.
- Addresses >= DEPTH: writes are ignored. Reads are accepted and return 0 with rd_valid=1.
- rd_data holds its last value while rd_valid=0.
- Reads and writes to different addresses in the same cycle are fully independent.

## Timing
- Reset values: busy=1, rd_valid=0, rd_data=0.
- Reads: a read accepted at edge k asserts rd_valid and presents rd_data after edge k+RD_LAT-1, i.e. usable at edge k+RD_LAT. Throughput is one read per cycle at either latency.
- Writes: a write at edge k is visible to a read accepted at edge k+1.
- rst or clr flushes the read pipeline. rd_valid is 0 from the next cycle and no in-flight read completes.
- Back-to-back reads with RD_LAT=2 produce consecutive rd_valid pulses with no bubble.

## Structure
- Shared package sync_ram_pkg holds:
  - RDW_READ_FIRST=0 and RDW_WRITE_FIRST=1 constants.
  - The two-state FSM enum.
  - A byte-merge function (old, new, be) -> merged word, which the clear path also uses with be all ones.
- Sub-module sync_ram_rd_pipe carries the valid/data pipeline for RD_LAT 1 or 2, with flush.
- Top level contains the storage array, write merge, collision mux and clear FSM.

## Test plan
- Reset clear: rst high 1 cycle with DEPTH=32. Expect busy high for 32 cycles, then reads of every address return 0.
- Byte write: write 0xABCD to addr 3 with be=2'b11, then 0x0012 with be=2'b01. A read of addr 3 must return 0xAB12.
- Collision: addr 7 holds 0x1111; write 0x2222 with be=11 and read addr 7 in the same cycle.
  - RDW_MODE=0 must return 0x1111.
  - RDW_MODE=1 must return 0x2222.
  - The next read of addr 7 returns 0x2222 in both modes.
- Latency and streaming: RD_LAT=2, reads of addr 0,1,2 on consecutive cycles. Expect rd_valid high for 3 consecutive cycles starting 2 cycles after the first read, with data in order.
- Mid-operation clear: with RD_LAT=2, issue a read, then pulse clr on the following cycle.
  - rd_valid must never assert for that read.
  - busy must be high for DEPTH cycles.
  - A write attempted during busy must not land.
- Out of range: DEPTH=20, ADDR_W=5. A write to addr 25 is ignored; a read of addr 25 returns 0 with rd_valid=1.
